// File: rtl/net_send_packet_fifo.sv
// Store-and-forward egress packet FIFO: buffers whole AXI-Stream frames and
// releases them only once committed; frames that do not fit are dropped whole.
module net_send_packet_fifo #(
    parameter int unsigned BUF_DATA_WIDTH = 512,
    parameter int unsigned BUF_KEEP_WIDTH = 64,
    parameter int unsigned DEPTH          = 64,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BUF_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [BUF_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [BUF_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [BUF_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [$clog2(DEPTH):0]    frame_count,
    output logic [CNT_WIDTH-1:0]      drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned EW = BUF_DATA_WIDTH + BUF_KEEP_WIDTH + 1;

    localparam logic [0:0] ST_ACCEPT = 1'b0;
    localparam logic [0:0] ST_DROP   = 1'b1;

    logic [0:0]           state_q,       state_d;
    logic [PW-1:0]        wr_ptr_q,      wr_ptr_d;
    logic [PW-1:0]        wr_commit_q,   wr_commit_d;
    logic [PW-1:0]        commit_vis_q,  commit_vis_d;
    logic [PW-1:0]        rd_ptr_q,      rd_ptr_d;
    logic                 out_valid_q,   out_valid_d;
    logic [EW-1:0]        out_entry_q,   out_entry_d;
    logic                 tready_q,      tready_d;
    logic [PW-1:0]        frame_count_q, frame_count_d;
    logic [CNT_WIDTH-1:0] drop_count_q,  drop_count_d;

    logic [EW-1:0] mem [DEPTH];

    logic          in_hs_c;
    logic          full_c;
    logic [PW-1:0] used_c;
    logic          mem_we_c;
    logic          commit_c;
    logic          load_c;
    logic          out_hs_c;

    // Write side: store, commit on tlast, roll back to last commit on overflow.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        wr_commit_d  = wr_commit_q;
        drop_count_d = drop_count_q;
        mem_we_c     = 1'b0;
        commit_c     = 1'b0;
        tready_d     = 1'b1;
        in_hs_c      = s_axis_tvalid & tready_q;
        used_c       = wr_ptr_q - rd_ptr_q;
        full_c       = (used_c == PW'(DEPTH));

        case (state_q)
            ST_ACCEPT: begin
                if (in_hs_c) begin
                    if (!full_c) begin
                        mem_we_c = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        if (s_axis_tlast) begin
                            wr_commit_d = wr_ptr_q + PW'(1);
                            commit_c    = 1'b1;
                        end
                    end else begin
                        wr_ptr_d = wr_commit_q;
                        if (drop_count_q != {CNT_WIDTH{1'b1}}) begin
                            drop_count_d = drop_count_q + CNT_WIDTH'(1);
                        end
                        if (!s_axis_tlast) begin
                            state_d = ST_DROP;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (in_hs_c && s_axis_tlast) begin
                    state_d = ST_ACCEPT;
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
    end

    // Read side: commit pointer is seen one cycle late; output register is the read stage.
    always_comb begin
        commit_vis_d  = wr_commit_q;
        rd_ptr_d      = rd_ptr_q;
        out_valid_d   = out_valid_q;
        out_entry_d   = out_entry_q;
        frame_count_d = frame_count_q;
        out_hs_c      = out_valid_q & m_axis_tready;
        load_c        = (rd_ptr_q != commit_vis_q) && (!out_valid_q || m_axis_tready);

        if (load_c) begin
            out_entry_d = mem[rd_ptr_q[AW-1:0]];
            out_valid_d = 1'b1;
            rd_ptr_d    = rd_ptr_q + PW'(1);
        end else if (out_hs_c) begin
            out_valid_d = 1'b0;
        end

        case ({commit_c, out_hs_c & out_entry_q[EW-1]})
            2'b10:   frame_count_d = frame_count_q + PW'(1);
            2'b01:   frame_count_d = frame_count_q - PW'(1);
            default: frame_count_d = frame_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_ACCEPT;
            wr_ptr_q      <= '0;
            wr_commit_q   <= '0;
            commit_vis_q  <= '0;
            rd_ptr_q      <= '0;
            out_valid_q   <= 1'b0;
            out_entry_q   <= '0;
            tready_q      <= 1'b0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            wr_commit_q   <= wr_commit_d;
            commit_vis_q  <= commit_vis_d;
            rd_ptr_q      <= rd_ptr_d;
            out_valid_q   <= out_valid_d;
            out_entry_q   <= out_entry_d;
            tready_q      <= tready_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    // Frame storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tdata  = out_entry_q[BUF_DATA_WIDTH-1:0];
    assign m_axis_tkeep  = out_entry_q[BUF_DATA_WIDTH +: BUF_KEEP_WIDTH];
    assign m_axis_tlast  = out_entry_q[EW-1];
    assign m_axis_tvalid = out_valid_q;
    assign frame_count   = frame_count_q;
    assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_net_send_packet_fifo.sv
// Scoreboard bench for net_send_packet_fifo with an 8-entry store.
module tb_net_send_packet_fifo;

    localparam int unsigned DW    = 512;
    localparam int unsigned KW    = 64;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 32;
    localparam int unsigned PW    = 4;
    localparam int unsigned EW    = DW + KW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_ready;
    logic [PW-1:0] frame_count;
    logic [CW-1:0] drop_count;

    logic [EW-1:0] exp_q [$];
    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    net_send_packet_fifo #(
        .BUF_DATA_WIDTH (DW),
        .BUF_KEEP_WIDTH (KW),
        .DEPTH          (DEPTH),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_ready),
        .frame_count   (frame_count),
        .drop_count    (drop_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] mk_data(input logic [7:0] tag, input int idx);
        logic [DW-1:0] d;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = {tag, 8'(idx), 16'(k)};
        return d;
    endfunction

    function automatic logic [KW-1:0] mk_keep(input int idx, input bit last);
        logic [KW-1:0] ones;
        ones = '1;
        return last ? (ones >> idx) : ones;
    endfunction

    // Monitor: pops the scoreboard on every egress handshake and checks stall stability.
    logic [EW-1:0] held;
    bit            stalled = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                if (m_tvalid && ({m_tlast, m_tkeep, m_tdata} === held)) passes++;
                else $display("FAIL hold_stable: got valid=%0b last=%0b data[63:0]=%h expected valid=1 last=%0b data[63:0]=%h",
                              m_tvalid, m_tlast, m_tdata[63:0], held[EW-1], held[63:0]);
            end
            if (m_tvalid && m_ready) begin
                logic [EW-1:0] e;
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_beat: got last=%0b keep=%h data[63:0]=%h expected no beat",
                             m_tlast, m_tkeep, m_tdata[63:0]);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_tlast, m_tkeep, m_tdata} === e) passes++;
                    else $display("FAIL egress_beat: got last=%0b keep=%h data=%h expected last=%0b keep=%h data=%h",
                                  m_tlast, m_tkeep, m_tdata, e[EW-1], e[DW +: KW], e[DW-1:0]);
                end
            end
            stalled = m_tvalid && !m_ready;
            held    = {m_tlast, m_tkeep, m_tdata};
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int len, input logic [7:0] tag, input bit pass);
        for (int i = 0; i < len; i++) begin
            s_tdata  = mk_data(tag, i);
            s_tlast  = (i == len - 1);
            s_tkeep  = mk_keep(i, s_tlast);
            s_tvalid = 1'b1;
            if (pass) exp_q.push_back({s_tlast, s_tkeep, s_tdata});
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        s_tvalid = 1'b0;
        m_ready  = 1'b1;
        idle(3);
        @(negedge clk);
        chk("reset_tready", 64'(s_tready), 64'd0);
        chk("reset_tvalid", 64'(m_tvalid), 64'd0);
        chk("reset_tdata", m_tdata[63:0], 64'd0);
        chk("reset_frame_count", 64'(frame_count), 64'd0);
        chk("reset_drop_count", 64'(drop_count), 64'd0);
        rst = 1'b0;
        idle(1);
        @(negedge clk);
        chk("post_reset_tready", 64'(s_tready), 64'd1);

        // Single 1-beat frame: latency and frame_count round trip.
        s_tdata  = {64{8'hA5}};
        s_tkeep  = '1;
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        exp_q.push_back({s_tlast, s_tkeep, s_tdata});
        idle(1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(negedge clk);
        chk("t1_fc_after_commit", 64'(frame_count), 64'd1);
        chk("t1_tvalid_t0", 64'(m_tvalid), 64'd0);
        @(negedge clk);
        chk("t1_tvalid_t1", 64'(m_tvalid), 64'd0);
        @(negedge clk);
        chk("t1_tvalid_t2", 64'(m_tvalid), 64'd1);
        @(negedge clk);
        chk("t1_tvalid_after", 64'(m_tvalid), 64'd0);
        chk("t1_fc_after", 64'(frame_count), 64'd0);

        // 3-beat frame under a 10-cycle egress stall, then a burst.
        m_ready = 1'b0;
        send_frame(3, 8'h20, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t2_fc_stall", 64'(frame_count), 64'd1);
        end
        chk("t2_tvalid_stall", 64'(m_tvalid), 64'd1);
        idle(1);
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_burst_valid", 64'(m_tvalid), 64'd1);
        end
        @(negedge clk);
        chk("t2_burst_end", 64'(m_tvalid), 64'd0);
        chk("t2_fc_end", 64'(frame_count), 64'd0);
        wait_drain("t2_drain", 20);

        // Exactly DEPTH beats into empty storage passes whole.
        send_frame(8, 8'h40, 1'b1);
        wait_drain("t4_drain", 40);
        idle(3);
        @(negedge clk);
        chk("t4_drop_count", 64'(drop_count), 64'd0);
        chk("t4_fc", 64'(frame_count), 64'd0);

        // Oversize frame dropped; following frame intact.
        send_frame(10, 8'h30, 1'b0);
        idle(5);
        @(negedge clk);
        chk("t3_drop_count", 64'(drop_count), 64'd1);
        chk("t3_fc", 64'(frame_count), 64'd0);
        chk("t3_tvalid", 64'(m_tvalid), 64'd0);
        send_frame(2, 8'h31, 1'b1);
        wait_drain("t3_drain", 20);

        // Stalled egress: A fits, B overflows and is dropped without residue.
        m_ready = 1'b0;
        send_frame(5, 8'h50, 1'b1);
        send_frame(5, 8'h51, 1'b0);
        idle(5);
        @(negedge clk);
        chk("t5_drop_count", 64'(drop_count), 64'd2);
        chk("t5_fc", 64'(frame_count), 64'd1);
        idle(1);
        m_ready = 1'b1;
        wait_drain("t5_drain_a", 30);
        idle(4);
        @(negedge clk);
        chk("t5_tvalid_empty", 64'(m_tvalid), 64'd0);
        chk("t5_fc_empty", 64'(frame_count), 64'd0);
        send_frame(3, 8'h52, 1'b1);
        wait_drain("t5_drain_c", 20);
        idle(3);

        // Reset in the middle of a 4-beat frame.
        for (int i = 0; i < 2; i++) begin
            s_tdata  = mk_data(8'h60, i);
            s_tkeep  = '1;
            s_tlast  = 1'b0;
            s_tvalid = 1'b1;
            idle(1);
        end
        s_tdata = mk_data(8'h60, 2);
        rst     = 1'b1;
        idle(2);
        @(negedge clk);
        chk("t6_tready_in_reset", 64'(s_tready), 64'd0);
        s_tvalid = 1'b0;
        rst      = 1'b0;
        idle(1);
        @(negedge clk);
        chk("t6_tvalid", 64'(m_tvalid), 64'd0);
        chk("t6_tdata", m_tdata[63:0], 64'd0);
        chk("t6_tlast", 64'(m_tlast), 64'd0);
        chk("t6_fc", 64'(frame_count), 64'd0);
        chk("t6_drop_count", 64'(drop_count), 64'd0);
        chk("t6_tready", 64'(s_tready), 64'd1);
        send_frame(1, 8'h61, 1'b1);
        wait_drain("t6_drain", 20);
        idle(4);
        @(negedge clk);
        chk("t6_final_tvalid", 64'(m_tvalid), 64'd0);
        chk("t6_final_fc", 64'(frame_count), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
